// File: rtl/e203_exu_wbck_arb_if.sv
// Write-back arbiter bus: ALU and long-pipe result streams in, register-file write port
// and long-pipe pending count out.
interface e203_exu_wbck_arb_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned PEND_W      = 2
) ();

    logic                   alu_wbck_i_valid;
    logic                   alu_wbck_i_ready;
    logic [XLEN-1:0]        alu_wbck_i_wdat;
    logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx;

    logic                   longp_wbck_i_valid;
    logic                   longp_wbck_i_ready;
    logic [XLEN-1:0]        longp_wbck_i_wdat;
    logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx;
    logic                   longp_wbck_i_err;

    logic                   rf_wbck_o_ena;
    logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx;
    logic [XLEN-1:0]        rf_wbck_o_wdat;

    logic [PEND_W-1:0]      longp_pend_cnt;

    // Arbiter side
    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        output alu_wbck_i_ready,
        input  longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx, longp_wbck_i_err,
        output longp_wbck_i_ready,
        output rf_wbck_o_ena, rf_wbck_o_rdidx, rf_wbck_o_wdat,
        output longp_pend_cnt
    );

    // Producer / register-file side
    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        input  alu_wbck_i_ready,
        output longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx, longp_wbck_i_err,
        input  longp_wbck_i_ready,
        input  rf_wbck_o_ena, rf_wbck_o_rdidx, rf_wbck_o_wdat,
        input  longp_pend_cnt
    );

endinterface

// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: ALU results (priority, zero latency) and FIFO-buffered long-pipe
// results share the register-file write port; a starvation counter forces FIFO slots.
module e203_exu_wbck_arb #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned RFIDX_WIDTH      = 5,
    parameter int unsigned LONGP_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    e203_exu_wbck_arb_if.slave    bus
);

    localparam int unsigned PTR_W = $clog2(LONGP_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic                   err;
        logic [RFIDX_WIDTH-1:0] rdidx;
        logic [XLEN-1:0]        wdat;
    } longp_ent_t;

    longp_ent_t       mem_q [LONGP_FIFO_DEPTH];
    longp_ent_t       mem_d [LONGP_FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STV_W-1:0] starve_q, starve_d;

    logic       fifo_nonempty;
    logic       fifo_full;
    logic       force_gnt;
    logic       fifo_gnt;
    logic       alu_gnt;
    logic       longp_push;
    logic       longp_pop;
    longp_ent_t head;

    // Grant and handshake
    always_comb begin
        fifo_nonempty = (cnt_q != '0);
        fifo_full     = (cnt_q == CNT_W'(LONGP_FIFO_DEPTH));
        head          = mem_q[rptr_q];
        force_gnt     = fifo_nonempty && (starve_q == STV_W'(STARVE_MAX));
        fifo_gnt      = fifo_nonempty && (force_gnt || !bus.alu_wbck_i_valid);
        alu_gnt       = bus.alu_wbck_i_valid && !force_gnt;
        longp_push    = bus.longp_wbck_i_valid && !fifo_full;
        longp_pop     = fifo_gnt;
    end

    assign bus.alu_wbck_i_ready   = !force_gnt;
    assign bus.longp_wbck_i_ready = !fifo_full;
    assign bus.longp_pend_cnt     = cnt_q;

    // Write-port mux; x0 and faulted results keep the handshake but drop the enable
    always_comb begin
        bus.rf_wbck_o_ena   = 1'b0;
        bus.rf_wbck_o_rdidx = '0;
        bus.rf_wbck_o_wdat  = '0;
        if (alu_gnt) begin
            bus.rf_wbck_o_rdidx = bus.alu_wbck_i_rdidx;
            bus.rf_wbck_o_wdat  = bus.alu_wbck_i_wdat;
            bus.rf_wbck_o_ena   = (bus.alu_wbck_i_rdidx != '0);
        end else if (fifo_gnt) begin
            bus.rf_wbck_o_rdidx = head.rdidx;
            bus.rf_wbck_o_wdat  = head.wdat;
            bus.rf_wbck_o_ena   = !head.err && (head.rdidx != '0);
        end
    end

    // FIFO and starvation counter next state
    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;

        if (longp_push) begin
            mem_d[wptr_q] = '{err:   bus.longp_wbck_i_err,
                              rdidx: bus.longp_wbck_i_rdidx,
                              wdat:  bus.longp_wbck_i_wdat};
            wptr_d        = PTR_W'(wptr_q + PTR_W'(1));
        end
        if (longp_pop) begin
            rptr_d = PTR_W'(rptr_q + PTR_W'(1));
        end
        case ({longp_push, longp_pop})
            2'b10:   cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            2'b01:   cnt_d = CNT_W'(cnt_q - CNT_W'(1));
            default: cnt_d = cnt_q;
        endcase

        if (fifo_gnt || !fifo_nonempty) begin
            starve_d = '0;
        end else if (alu_gnt && (starve_q != STV_W'(STARVE_MAX))) begin
            starve_d = STV_W'(starve_q + STV_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LONGP_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(longp_pop && !fifo_nonempty));
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(longp_push && fifo_full));

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Scoreboard bench for the write-back arbiter: a cycle model queues expected port values
// as stimulus is driven; they are popped and compared on the falling edge.
module tb_e203_exu_wbck_arb;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned RIW        = 5;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned PEND_W     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic            err;
        logic [RIW-1:0]  idx;
        logic [XLEN-1:0] dat;
    } ent_t;

    typedef struct packed {
        logic            ena;
        logic [RIW-1:0]  idx;
        logic [XLEN-1:0] dat;
        logic            alu_rdy;
        logic            lp_rdy;
        logic [31:0]     pend;
    } exp_t;

    logic clk;
    logic rst;

    e203_exu_wbck_arb_if #(.XLEN(XLEN), .RFIDX_WIDTH(RIW), .PEND_W(PEND_W)) bus ();

    e203_exu_wbck_arb #(
        .XLEN(XLEN), .RFIDX_WIDTH(RIW), .LONGP_FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t lp_src[$];
    ent_t mfifo[$];
    int   mstarve = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // One clock cycle, entered and left at posedge+1
    task automatic cycle(input bit av, input logic [RIW-1:0] ai, input logic [XLEN-1:0] ad);
        ent_t lp;
        ent_t h;
        bit   lv, nonempty, full, frc, fgnt, agnt;
        exp_t e;
        exp_t g;

        lv = (lp_src.size() > 0);
        lp = lv ? lp_src[0] : ent_t'($urandom);
        bus.alu_wbck_i_valid   = av;
        bus.alu_wbck_i_rdidx   = ai;
        bus.alu_wbck_i_wdat    = ad;
        bus.longp_wbck_i_valid = lv;
        bus.longp_wbck_i_err   = lp.err;
        bus.longp_wbck_i_rdidx = lp.idx;
        bus.longp_wbck_i_wdat  = lp.dat;

        nonempty = (mfifo.size() > 0);
        full     = (mfifo.size() == DEPTH);
        frc      = nonempty && (mstarve == STARVE_MAX);
        fgnt     = nonempty && (frc || !av);
        agnt     = av && !frc;
        e        = '0;
        e.alu_rdy = !frc;
        e.lp_rdy  = !full;
        e.pend    = mfifo.size();
        if (agnt) begin
            e.ena = (ai != 0);
            e.idx = ai;
            e.dat = ad;
        end else if (fgnt) begin
            h     = mfifo[0];
            e.ena = !h.err && (h.idx != 0);
            e.idx = h.idx;
            e.dat = h.dat;
        end
        exp_q.push_back(e);

        @(negedge clk);
        g = exp_q.pop_front();
        check("rf_ena",    64'(bus.rf_wbck_o_ena),      64'(g.ena));
        check("rf_rdidx",  64'(bus.rf_wbck_o_rdidx),    64'(g.idx));
        check("rf_wdat",   64'(bus.rf_wbck_o_wdat),     64'(g.dat));
        check("alu_ready", 64'(bus.alu_wbck_i_ready),   64'(g.alu_rdy));
        check("lp_ready",  64'(bus.longp_wbck_i_ready), 64'(g.lp_rdy));
        check("pend_cnt",  64'(bus.longp_pend_cnt),     64'(g.pend));

        @(posedge clk);
        if (fgnt) void'(mfifo.pop_front());
        if (lv && !full) begin
            mfifo.push_back(lp);
            void'(lp_src.pop_front());
        end
        if (fgnt || !nonempty) mstarve = 0;
        else if (agnt && mstarve < STARVE_MAX) mstarve++;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ena"},     64'(bus.rf_wbck_o_ena),      64'(0));
        check({tag, "_rdidx"},   64'(bus.rf_wbck_o_rdidx),    64'(0));
        check({tag, "_wdat"},    64'(bus.rf_wbck_o_wdat),     64'(0));
        check({tag, "_pend"},    64'(bus.longp_pend_cnt),     64'(0));
        check({tag, "_alu_rdy"}, 64'(bus.alu_wbck_i_ready),   64'(1));
        check({tag, "_lp_rdy"},  64'(bus.longp_wbck_i_ready), 64'(1));
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.alu_wbck_i_valid   = 1'b0;
        bus.alu_wbck_i_rdidx   = '0;
        bus.alu_wbck_i_wdat    = '0;
        bus.longp_wbck_i_valid = 1'b0;
        bus.longp_wbck_i_err   = 1'b0;
        bus.longp_wbck_i_rdidx = '0;
        bus.longp_wbck_i_wdat  = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU only, zero latency
        cycle(1'b1, 5'd5, 32'h1234_5678);
        cycle(1'b0, 5'd0, 32'h0);

        // Long-pipe only: written one cycle after the push
        lp_src.push_back('{err: 1'b0, idx: 5'd7, dat: 32'hDEAD_BEEF});
        repeat (3) cycle(1'b0, 5'd0, 32'h0);

        // Contention: forced slot after STARVE_MAX ALU wins
        lp_src.push_back('{err: 1'b0, idx: 5'd9, dat: 32'h9999_0009});
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'd1, 32'hA000_0000 + 32'(i));

        // Full FIFO under continuous ALU traffic
        lp_src.push_back('{err: 1'b0, idx: 5'd10, dat: 32'hB000_000A});
        lp_src.push_back('{err: 1'b0, idx: 5'd11, dat: 32'hB000_000B});
        lp_src.push_back('{err: 1'b0, idx: 5'd12, dat: 32'hB000_000C});
        for (int i = 0; i < 16; i++) cycle(1'b1, 5'd2, 32'hC000_0000 + 32'(i));
        repeat (3) cycle(1'b0, 5'd0, 32'h0);

        // x0 and faulted long-pipe results
        cycle(1'b1, 5'd0, 32'h5555_5555);
        lp_src.push_back('{err: 1'b1, idx: 5'd4, dat: 32'hE000_0004});
        lp_src.push_back('{err: 1'b0, idx: 5'd0, dat: 32'hE000_0000});
        lp_src.push_back('{err: 1'b0, idx: 5'd3, dat: 32'hE000_0003});
        repeat (5) cycle(1'b0, 5'd0, 32'h0);

        // Random mixed traffic
        for (int i = 0; i < 300; i++) begin
            if (lp_src.size() < 2 && $urandom_range(0, 2) == 0) begin
                lp_src.push_back('{err: ($urandom_range(0, 7) == 0),
                                   idx: 5'($urandom), dat: 32'($urandom)});
            end
            cycle(bit'($urandom_range(0, 1)), 5'($urandom), 32'($urandom));
        end
        while (lp_src.size() > 0 && n_checks < 100000) cycle(1'b1, 5'd6, 32'h6666_6666);
        repeat (4) cycle(1'b0, 5'd0, 32'h0);
        check("lp_drained", 64'(lp_src.size()), 64'(0));

        // Async reset with two entries pending
        lp_src.push_back('{err: 1'b0, idx: 5'd20, dat: 32'hF000_0014});
        lp_src.push_back('{err: 1'b0, idx: 5'd21, dat: 32'hF000_0015});
        cycle(1'b1, 5'd8, 32'h8888_0000);
        cycle(1'b1, 5'd8, 32'h8888_0001);
        check("pend_before_rst", 64'(bus.longp_pend_cnt), 64'(mfifo.size()));
        bus.alu_wbck_i_valid   = 1'b0;
        bus.longp_wbck_i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        mfifo.delete();
        lp_src.delete();
        mstarve = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (6) cycle(1'b0, 5'd0, 32'h0);
        cycle(1'b1, 5'd13, 32'h1313_1313);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/e203_exu_wbck_arb.md
Name: e203_exu_wbck_arb

Overview:
- Write-back arbiter directly upstream of the general-purpose register file. It merges the single-cycle ALU result stream and the long-pipe (multiply/divide, load) result stream into the register file's single write port (wen/idx/dat).
- Long-pipe results are buffered in a small FIFO. The ALU has priority, and an anti-starvation counter guarantees forward progress for buffered long-pipe results.
- A pending-entry count is exported for hazard checking in dispatch.

Parameters:
- XLEN, 32, data width of write-back data.
- RFIDX_WIDTH, 5, register index width.
- LONGP_FIFO_DEPTH, 2, long-pipe buffer entries (power of 2, >=2).
- STARVE_MAX, 3, consecutive ALU-won cycles while the FIFO is non-empty before the FIFO is forced a slot (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_wbck_i_valid  input  1  ALU result valid.
- alu_wbck_i_ready  output  1  ALU result accepted this cycle.
- alu_wbck_i_wdat  input  XLEN  ALU result data.
- alu_wbck_i_rdidx  input  RFIDX_WIDTH  ALU destination index.
- longp_wbck_i_valid  input  1  long-pipe result valid.
- longp_wbck_i_ready  output  1  long-pipe result accepted into the FIFO.
- longp_wbck_i_wdat  input  XLEN  long-pipe result data.
- longp_wbck_i_rdidx  input  RFIDX_WIDTH  long-pipe destination index.
- longp_wbck_i_err  input  1  long-pipe result faulted; no register write.
- rf_wbck_o_ena  output  1  register file write enable.
- rf_wbck_o_rdidx  output  RFIDX_WIDTH  register file write index.
- rf_wbck_o_wdat  output  XLEN  register file write data.
- longp_pend_cnt  output  $clog2(LONGP_FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count cleared; starvation counter cleared.
  - Resulting outputs: rf_wbck_o_ena=0, rf_wbck_o_rdidx=0, rf_wbck_o_wdat=0, longp_pend_cnt=0, alu_wbck_i_ready=1, longp_wbck_i_ready=1.
  - Reset mid-operation discards all buffered entries.
- Long-pipe intake:
  - longp_wbck_i_ready = !full.
  - An entry is pushed when valid & ready, storing {err, rdidx, wdat}.
  - The data never bypasses the FIFO: an entry pushed in cycle N is eligible for write-back at the earliest in cycle N+1.
- Grant, evaluated combinationally each cycle:
  - force = fifo_nonempty & (starve_cnt == STARVE_MAX).
  - fifo_gnt = fifo_nonempty & (force | !alu_wbck_i_valid).
  - alu_gnt = alu_wbck_i_valid & !force.
  - alu_wbck_i_ready = !force. The ALU write has zero latency: written in the same cycle it is presented.
- Output mux:
  - When alu_gnt: rdidx/wdat come from the ALU and ena=1.
  - When fifo_gnt: rdidx/wdat come from the FIFO head and ena=!head.err. The head is popped regardless of err.
  - Otherwise: ena=0 and rdidx/wdat are driven to 0.
- x0 writes:
  - Any granted write with rdidx==0 gives ena=0, but the handshake/pop still completes.
  - The data path still shows the value; only ena is suppressed.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when alu_gnt & fifo_nonempty.
  - Clears on fifo_gnt or when the FIFO is empty.
- Simultaneous push and pop:
  - With the FIFO full: pop frees the slot next cycle only, so ready stays 0 this cycle (no same-cycle full bypass).
  - With the FIFO non-full: count is unchanged.
- Pointers wrap modulo LONGP_FIFO_DEPTH.
- longp_pend_cnt equals the occupancy after the last clock edge.
- FIFO underflow and overflow are impossible by construction; assertions check both.

Test Plan:
- Reset, then ALU only: alu_valid=1, rdidx=5, wdat=0x12345678 -> same cycle ena=1, idx=5, dat=0x12345678, alu_ready=1; longp_pend_cnt=0.
- Long-pipe only: push rdidx=7, wdat=0xDEADBEEF in cycle 0 -> cycle 0 ena=0, pend=1 after the edge; cycle 1 ena=1, idx=7, dat=0xDEADBEEF; pend=0 after cycle 1.
- Contention and starvation, defaults:
  - Stimulus: ALU valid continuously (idx=1); one long-pipe entry (idx=9) pushed in cycle 0.
  - Cycles 1-3: ALU written.
  - Cycle 4: force, alu_ready=0, idx=9 written.
  - Cycle 5: ALU resumes.
- Full FIFO: ALU valid continuously, 3 long-pipe pushes back-to-back -> third push sees longp_ready=0 until the forced pop; no entry lost or duplicated, written in order.
- x0 and err:
  - ALU idx=0 -> ena=0, alu_ready=1.
  - Long-pipe err=1, idx=4 -> popped, ena=0, pend decrements.
- Async reset with pend=2 mid-stream -> immediately ena=0, pend=0, both readies=1; stale entries never written after reset release.
